paint_scheduler: RTL
====================

Name: paint_scheduler

Overview:
Sequences brush-stroke paint commands into single-pixel writes on the pixelStore write port. Commands come from the SPI command decoder: a centre point, a colour code and a brush flag. Each command is buffered in a small FIFO and expanded into a clipped square of pixels. Each write is issued only in a cycle when the VGA read side has released the store, so the scan-out is never disturbed.

Parameters:
H_RES, 640, visible columns; x valid range 0..H_RES-1
V_RES, 480, visible rows; y valid range 0..V_RES-1
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
BRUSH_R, 1, brush radius; square side = 2*BRUSH_R+1

Ports:
clk  in  1  25.175 MHz pixel clock
reset_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; combinational = ~full
cmd_x  in  10  centre column
cmd_y  in  10  centre row
cmd_color  in  3  colour code
cmd_brush  in  1  1 = paint cmd_color, 0 = erase (colour code 0)
rd_busy_next  in  1  VGA read occupies pixelStore in the next cycle
wr_en  out  1  registered write strobe to pixelStore
wr_x  out  10  registered write column
wr_y  out  10  registered write row
wr_color  out  3  registered write colour code
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently held in the FIFO

Behaviour:
- Reset (async, reset_n=0): FIFO flushed, FSM to IDLE, counters cleared.
  - Reset values: wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, fifo_count=0, cmd_ready=1.
  - Reset mid-stroke abandons the stroke; wr_en falls immediately (asynchronously).
- FIFO push: on a clk edge where cmd_valid & cmd_ready, store {x, y, colour}.
  - Stored colour = cmd_brush ? cmd_color : 3'b000.
  - cmd_ready is derived from fifo_count only; a pop in the same cycle does not raise it.
  - When full, cmd_ready=0 and the producer holds its command.
- FSM has two states: IDLE and PAINT.
  - IDLE: if the FIFO is non-empty, pop the head on the edge and latch cx, cy, col. Set dx=-BRUSH_R, dy=-BRUSH_R, go to PAINT. Otherwise stay in IDLE.
  - PAINT, rd_busy_next=1: stall. Next wr_en=0; dx and dy hold.
  - PAINT, rd_busy_next=0: evaluate px=cx+dx and py=cy+dy as 12-bit signed.
    - If 0<=px<H_RES and 0<=py<V_RES: next wr_en=1 with wr_x=px[9:0], wr_y=py[9:0], wr_color=col.
    - Otherwise next wr_en=0 (clipped); the pixel slot is still consumed.
    - Scan order is row-major: dx increments first. At dx=BRUSH_R, dx wraps to -BRUSH_R and dy increments.
    - When dx=dy=BRUSH_R has been evaluated, go to IDLE.
- One FSM cycle in IDLE sits between consecutive strokes.
- Latency: command accepted at edge N → popped at edge N+1 → first wr_en high after edge N+2 (given rd_busy_next=0).
  - One unclipped stroke produces (2R+1)^2 consecutive writes (9 for R=1).
- wr_x, wr_y and wr_color hold their last values while wr_en=0.
- Out-of-range centres (e.g. x>=H_RES) are not rejected. Clipping suppresses every pixel, so the stroke takes the full (2R+1)^2 evaluation cycles with no writes.
- busy is registered from the next-state values: high from the edge after acceptance until the edge returning to IDLE with the FIFO empty.

Test Plan:
1. Single stroke: push (100,50), colour 5, brush=1, with rd_busy_next=0 → 9 writes on consecutive cycles, starting 2 edges after acceptance. Order (99,49),(100,49),(101,49),(99,50)…(101,51), all wr_color=5; busy returns to 0.
2. Clipping: push (0,0) → exactly 4 writes (0,0),(1,0),(0,1),(1,1) over 9 PAINT cycles. Push (639,479) → writes (638,478),(639,478),(638,479),(639,479). Push (1000,10) → zero writes, stroke still completes.
3. Erase: push (20,20), colour 5, brush=0 → 9 writes, all with wr_color=0.
4. Stall: single stroke with rd_busy_next=1 for 5 cycles after the 3rd write → wr_en=0 throughout the stall. Resumes at (99,50); exactly 9 writes total, no duplicated or skipped pixel.
5. Backpressure: hold rd_busy_next=1 and offer 6 back-to-back commands → 5 accepted (1 in FSM, 4 in FIFO); cmd_ready=0 and fifo_count=4. Release rd_busy_next → 6th accepted on the edge after the first FIFO pop; all 6 strokes written in order.
6. Reset mid-stroke: assert reset_n=0 after the 4th write with 2 commands queued → wr_en=0 immediately, busy=0, fifo_count=0, cmd_ready=1. No writes occur after reset release until a new command is pushed.

Source files
------------

// File: rtl/paint_scheduler.sv
// Paint scheduler: buffers brush commands in a small FIFO and expands each one
// into a clipped square of single-pixel writes, issued only when VGA scan-out leaves the store free.
module paint_scheduler #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int BRUSH_R    = 1,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [9:0]    i_cmd_x,
    input  logic [9:0]    i_cmd_y,
    input  logic [2:0]    i_cmd_color,
    input  logic          i_cmd_brush,
    input  logic          i_rd_busy_next,
    output logic          o_wr_en,
    output logic [9:0]    o_wr_x,
    output logic [9:0]    o_wr_y,
    output logic [2:0]    o_wr_color,
    output logic          o_busy,
    output logic [CW-1:0] o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [11:0] R_POS = 12'(BRUSH_R);
    localparam logic signed [11:0] R_NEG = -R_POS;
    localparam logic signed [11:0] H_LIM = 12'(H_RES);
    localparam logic signed [11:0] V_LIM = 12'(V_RES);

    typedef enum logic {S_IDLE, S_PAINT} state_t;

    state_t             r_state, w_stateNext;
    logic [AW-1:0]      r_wrPtr, r_rdPtr;
    logic [CW-1:0]      r_count, w_countNext;
    logic [9:0]         r_fifoX   [FIFO_DEPTH];
    logic [9:0]         r_fifoY   [FIFO_DEPTH];
    logic [2:0]         r_fifoCol [FIFO_DEPTH];
    logic [9:0]         r_cx, r_cy;
    logic [2:0]         r_col;
    logic signed [11:0] r_dx, r_dy, w_dxNext, w_dyNext;
    logic signed [11:0] w_px, w_py;
    logic               w_inRange;
    logic               w_push, w_pop;
    logic [2:0]         w_pushColor;
    logic               w_wrEnNext;
    logic [9:0]         w_wrXNext, w_wrYNext;
    logic [2:0]         w_wrColorNext;
    logic               w_busyNext;

    // Readiness looks only at the current fill level, so a same-cycle pop never admits a push.
    assign o_cmd_ready  = (r_count != CW'(FIFO_DEPTH));
    assign o_fifo_count = r_count;
    assign w_push       = i_cmd_valid & o_cmd_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_countNext  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_pushColor  = i_cmd_brush ? i_cmd_color : 3'b000;

    assign w_px      = $signed({2'b00, r_cx}) + r_dx;
    assign w_py      = $signed({2'b00, r_cy}) + r_dy;
    assign w_inRange = !w_px[11] && (w_px < H_LIM) && !w_py[11] && (w_py < V_LIM);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoX[r_wrPtr]   <= i_cmd_x;
            r_fifoY[r_wrPtr]   <= i_cmd_y;
            r_fifoCol[r_wrPtr] <= w_pushColor;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_dxNext      = r_dx;
        w_dyNext      = r_dy;
        w_wrEnNext    = 1'b0;
        w_wrXNext     = o_wr_x;
        w_wrYNext     = o_wr_y;
        w_wrColorNext = o_wr_color;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_stateNext = S_PAINT;
                    w_dxNext    = R_NEG;
                    w_dyNext    = R_NEG;
                end
            end
            S_PAINT: begin
                // A clipped pixel still uses its slot, so every stroke lasts the full square.
                if (!i_rd_busy_next) begin
                    if (w_inRange) begin
                        w_wrEnNext    = 1'b1;
                        w_wrXNext     = w_px[9:0];
                        w_wrYNext     = w_py[9:0];
                        w_wrColorNext = r_col;
                    end
                    if (r_dx == R_POS) begin
                        w_dxNext = R_NEG;
                        if (r_dy == R_POS) begin
                            w_stateNext = S_IDLE;
                        end else begin
                            w_dyNext = r_dy + 12'sd1;
                        end
                    end else begin
                        w_dxNext = r_dx + 12'sd1;
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
        w_busyNext = (w_stateNext != S_IDLE) || (w_countNext != '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_col      <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            o_wr_en    <= 1'b0;
            o_wr_x     <= '0;
            o_wr_y     <= '0;
            o_wr_color <= '0;
            o_busy     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_dx    <= w_dxNext;
            r_dy    <= w_dyNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_cx    <= r_fifoX[r_rdPtr];
                r_cy    <= r_fifoY[r_rdPtr];
                r_col   <= r_fifoCol[r_rdPtr];
            end
            o_wr_en    <= w_wrEnNext;
            o_wr_x     <= w_wrXNext;
            o_wr_y     <= w_wrYNext;
            o_wr_color <= w_wrColorNext;
            o_busy     <= w_busyNext;
        end
    end

endmodule
